// File: rtl/vga_pkg.sv
// vga_pkg: standard raster mode constants and counter-width helper
package vga_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_H_POL    = 1'b0;
    localparam bit VGA640_V_POL    = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam bit SVGA800_H_POL    = 1'b1;
    localparam bit SVGA800_V_POL    = 1'b1;

    // Bits needed to represent 0..n-1
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated W-bit shift register of depth D (D=0 is a wire)
module vga_delay_line #(
    parameter int           W       = 1,
    parameter int           D       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_En,
    input  logic [W-1:0] i_D,
    output logic [W-1:0] o_Q
);

    if (D == 0) begin : g_pass
        logic unused_ctl;
        assign unused_ctl = ^{i_Clk, i_Rst, i_En};
        assign o_Q = i_D;
    end else begin : g_sr
        logic [D-1:0][W-1:0] sr_q;
        // Shift one stage per enabled clock; stage 0 takes the input
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                sr_q <= {D{RST_VAL}};
            end else if (i_En) begin
                sr_q[0] <= i_D;
                for (int i = 1; i < D; i++) sr_q[i] <= sr_q[i-1];
            end
        end
        assign o_Q = sr_q[D-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster counters with registered sync/active decode and strobes
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit H_POL    = VGA640_H_POL,
    parameter bit V_POL    = VGA640_V_POL,
    parameter int DELAY    = 0,
    parameter int CNT_W    = 10
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_En,
    output logic [CNT_W-1:0] o_Col_Count,
    output logic [CNT_W-1:0] o_Row_Count,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic             o_Active,
    output logic             o_Line_Start,
    output logic             o_Frame_Start,
    output logic             o_HSync_Dly,
    output logic             o_VSync_Dly,
    output logic             o_Active_Dly
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    if (clog2(H_TOTAL) > CNT_W || clog2(V_TOTAL) > CNT_W) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 or V_TOTAL-1");
    end
    if (DELAY < 0 || DELAY > 15) begin : g_bad_delay
        $error("vga_timing_gen: DELAY must be within 0..15");
    end

    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic             hs_q, hs_d, vs_q, vs_d, act_q, act_d;
    logic             line_q, line_d, frame_q, frame_d;
    logic             col_wrap, row_wrap;

    // Next-state counts, then decode from those counts so outputs match the counts they accompany
    always_comb begin
        col_wrap = i_En && (int'(col_q) == H_TOTAL - 1);
        row_wrap = col_wrap && (int'(row_q) == V_TOTAL - 1);
        col_d    = col_wrap ? '0 : col_q + CNT_W'(i_En);
        row_d    = row_wrap ? '0 : row_q + CNT_W'(col_wrap);
        hs_d     = (int'(col_d) >= HS_START && int'(col_d) < HS_END) ? H_POL : ~H_POL;
        vs_d     = (int'(row_d) >= VS_START && int'(row_d) < VS_END) ? V_POL : ~V_POL;
        act_d    = int'(col_d) < H_ACTIVE && int'(row_d) < V_ACTIVE;
        line_d   = col_wrap;
        frame_d  = row_wrap;
    end

    // Register counts, decoded signals and strobes; reset state describes position (0,0)
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            col_q   <= '0;
            row_q   <= '0;
            hs_q    <= ~H_POL;
            vs_q    <= ~V_POL;
            act_q   <= 1'b1;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            act_q   <= act_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_HSync       = hs_q;
    assign o_VSync       = vs_q;
    assign o_Active      = act_q;
    assign o_Line_Start  = line_q;
    assign o_Frame_Start = frame_q;

    vga_delay_line #(
        .W      (3),
        .D      (DELAY),
        .RST_VAL({~H_POL, ~V_POL, 1'b0})
    ) u_dly (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .i_En (i_En),
        .i_D  ({hs_q, vs_q, act_q}),
        .o_Q  ({o_HSync_Dly, o_VSync_Dly, o_Active_Dly})
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized checks of three raster configurations against a position-based model
module tb_vga_timing_gen;

    typedef struct packed {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
        int dl;
    } mode_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_def = 1'b0, en_sm = 1'b0, en_pol = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int k_def = 0, k_sm = 0, k_pol = 0;
    bit adv_def = 0, adv_sm = 0, adv_pol = 0;
    mode_t m_def, m_sm, m_pol;

    logic [9:0] d_col, d_row, s_col, s_row, p_col, p_row;
    logic d_hs, d_vs, d_act, d_ls, d_fs, d_hsd, d_vsd, d_actd;
    logic s_hs, s_vs, s_act, s_ls, s_fs, s_hsd, s_vsd, s_actd;
    logic p_hs, p_vs, p_act, p_ls, p_fs, p_hsd, p_vsd, p_actd;

    logic [27:0] got_def, got_sm, got_pol;
    assign got_def = {d_col, d_row, d_hs, d_vs, d_act, d_ls, d_fs, d_hsd, d_vsd, d_actd};
    assign got_sm  = {s_col, s_row, s_hs, s_vs, s_act, s_ls, s_fs, s_hsd, s_vsd, s_actd};
    assign got_pol = {p_col, p_row, p_hs, p_vs, p_act, p_ls, p_fs, p_hsd, p_vsd, p_actd};

    vga_timing_gen u_def (
        .i_Clk(clk), .i_Rst(rst), .i_En(en_def),
        .o_Col_Count(d_col), .o_Row_Count(d_row), .o_HSync(d_hs), .o_VSync(d_vs),
        .o_Active(d_act), .o_Line_Start(d_ls), .o_Frame_Start(d_fs),
        .o_HSync_Dly(d_hsd), .o_VSync_Dly(d_vsd), .o_Active_Dly(d_actd)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .DELAY(3)
    ) u_sm (
        .i_Clk(clk), .i_Rst(rst), .i_En(en_sm),
        .o_Col_Count(s_col), .o_Row_Count(s_row), .o_HSync(s_hs), .o_VSync(s_vs),
        .o_Active(s_act), .o_Line_Start(s_ls), .o_Frame_Start(s_fs),
        .o_HSync_Dly(s_hsd), .o_VSync_Dly(s_vsd), .o_Active_Dly(s_actd)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .DELAY(0)
    ) u_pol (
        .i_Clk(clk), .i_Rst(rst), .i_En(en_pol),
        .o_Col_Count(p_col), .o_Row_Count(p_row), .o_HSync(p_hs), .o_VSync(p_vs),
        .o_Active(p_act), .o_Line_Start(p_ls), .o_Frame_Start(p_fs),
        .o_HSync_Dly(p_hsd), .o_VSync_Dly(p_vsd), .o_Active_Dly(p_actd)
    );

    // {hsync, vsync, active} of the raster position reached after k advances
    function automatic logic [2:0] exp_sig(mode_t m, int k);
        int ht = m.ha + m.hf + m.hs + m.hb;
        int vt = m.va + m.vf + m.vs + m.vb;
        int c = k % ht;
        int r = (k / ht) % vt;
        logic hs = (c >= m.ha + m.hf && c < m.ha + m.hf + m.hs) ? m.hp : !m.hp;
        logic vs = (r >= m.va + m.vf && r < m.va + m.vf + m.vs) ? m.vp : !m.vp;
        return {hs, vs, logic'(c < m.ha && r < m.va)};
    endfunction

    // Delayed copy: the position dl advances ago, or the idle tuple before that many advances
    function automatic logic [2:0] exp_dly(mode_t m, int k);
        return (k >= m.dl) ? exp_sig(m, k - m.dl) : {!m.hp, !m.vp, 1'b0};
    endfunction

    // Full expected output vector after k advances; adv says whether the last clock advanced
    function automatic logic [27:0] exp_vec(mode_t m, int k, bit adv);
        int ht = m.ha + m.hf + m.hs + m.hb;
        int vt = m.va + m.vf + m.vs + m.vb;
        int c = k % ht;
        int r = (k / ht) % vt;
        logic ls = adv && c == 0;
        logic fs = ls && r == 0;
        return {10'(c), 10'(r), exp_sig(m, k), ls, fs, exp_dly(m, k)};
    endfunction

    // One clock: drive enables at the falling edge, advance the model at the rising edge
    task automatic step(input bit a, input bit b, input bit c);
        en_def = a;
        en_sm  = b;
        en_pol = c;
        @(posedge clk);
        k_def += int'(a); adv_def = a;
        k_sm  += int'(b); adv_sm  = b;
        k_pol += int'(c); adv_pol = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en_def = 0; en_sm = 0; en_pol = 0;
        @(negedge clk);
        rst = 1'b0;
        k_def = 0; k_sm = 0; k_pol = 0;
        adv_def = 0; adv_sm = 0; adv_pol = 0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (5) step(1, 1, 1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp += 3;
            if (got_def !== exp_vec(m_def, 0, 0)) begin
                n_bad++;
                $display("FAIL reset_def[%0d]: got %h expected %h", i, got_def, exp_vec(m_def, 0, 0));
            end
            if (got_sm !== exp_vec(m_sm, 0, 0)) begin
                n_bad++;
                $display("FAIL reset_small[%0d]: got %h expected %h", i, got_sm, exp_vec(m_sm, 0, 0));
            end
            if (got_pol !== exp_vec(m_pol, 0, 0)) begin
                n_bad++;
                $display("FAIL reset_pol[%0d]: got %h expected %h", i, got_pol, exp_vec(m_pol, 0, 0));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (p_hs !== 1'b0 || p_vs !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_pol_sync_level: got hs=%b vs=%b expected 0 0", p_hs, p_vs);
        end
        rst = 1'b0;
        k_def = 0; k_sm = 0; k_pol = 0;
        step(1, 1, 1);
        n_cmp++;
        if (got_def !== exp_vec(m_def, 1, 1)) begin
            n_bad++;
            $display("FAIL reset_release_first_edge: got %h expected %h", got_def, exp_vec(m_def, 1, 1));
        end
    endtask

    task automatic test_default_hsync();
        int lo_n = 0, lo_first = -1, vs_lo = 0;
        do_reset();
        for (int i = 0; i < 1700; i++) begin
            step(1, 0, 0);
            n_cmp++;
            if (got_def !== exp_vec(m_def, k_def, adv_def)) begin
                n_bad++;
                $display("FAIL default_seq k=%0d: got %h expected %h", k_def, got_def, exp_vec(m_def, k_def, adv_def));
            end
            if (d_hs == 1'b0) begin
                lo_n++;
                if (lo_first < 0) lo_first = int'(d_col);
            end
            if (d_vs == 1'b0) vs_lo++;
        end
        n_cmp += 3;
        if (lo_first != 656) begin
            n_bad++;
            $display("FAIL default_hsync_first_col: got %0d expected 656", lo_first);
        end
        if (lo_n != 192) begin
            n_bad++;
            $display("FAIL default_hsync_low_count: got %0d expected 192", lo_n);
        end
        if (vs_lo != 0) begin
            n_bad++;
            $display("FAIL default_vsync_rows_0_2: got %0d low samples expected 0", vs_lo);
        end
    endtask

    task automatic test_small_periods();
        int ls_n = 0, fs_n = 0, act_n = 0, fs_first = -1, fs_last = -1, pvs_n = 0;
        do_reset();
        for (int i = 0; i < 96; i++) begin
            step(0, 1, 1);
            n_cmp += 2;
            if (got_sm !== exp_vec(m_sm, k_sm, adv_sm)) begin
                n_bad++;
                $display("FAIL small_seq k=%0d: got %h expected %h", k_sm, got_sm, exp_vec(m_sm, k_sm, adv_sm));
            end
            if (got_pol !== exp_vec(m_pol, k_pol, adv_pol)) begin
                n_bad++;
                $display("FAIL pol_seq k=%0d: got %h expected %h", k_pol, got_pol, exp_vec(m_pol, k_pol, adv_pol));
            end
            ls_n  += int'(s_ls);
            act_n += int'(s_act);
            pvs_n += int'(p_vs);
            if (s_fs) begin
                fs_n++;
                if (fs_first < 0) fs_first = k_sm;
                fs_last = k_sm;
            end
        end
        n_cmp += 6;
        if (ls_n != 12) begin
            n_bad++;
            $display("FAIL small_line_starts: got %0d expected 12", ls_n);
        end
        if (fs_n != 2) begin
            n_bad++;
            $display("FAIL small_frame_starts: got %0d expected 2", fs_n);
        end
        if (fs_first != 48) begin
            n_bad++;
            $display("FAIL small_first_frame_start: got clk %0d expected 48", fs_first);
        end
        if (fs_last != 96) begin
            n_bad++;
            $display("FAIL small_frame_period: got clk %0d expected 96", fs_last);
        end
        if (act_n != 24) begin
            n_bad++;
            $display("FAIL small_active_count: got %0d expected 24", act_n);
        end
        if (pvs_n != 16) begin
            n_bad++;
            $display("FAIL pol_vsync_high_count: got %0d expected 16", pvs_n);
        end
    endtask

    task automatic test_delay_startup();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (s_hsd !== 1'b1 || s_vsd !== 1'b1 || s_actd !== 1'b0) begin
                n_bad++;
                $display("FAIL delay_startup[%0d]: got %b%b%b expected 110", i, s_hsd, s_vsd, s_actd);
            end
            step(0, 1, 0);
        end
        n_cmp++;
        if (s_actd !== 1'b1) begin
            n_bad++;
            $display("FAIL delay_fourth_sample_active: got %b expected 1", s_actd);
        end
    endtask

    task automatic test_enable_stall();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0);
            n_cmp += 3;
            if (got_def !== exp_vec(m_def, k_def, adv_def)) begin
                n_bad++;
                $display("FAIL stall_def k=%0d: got %h expected %h", k_def, got_def, exp_vec(m_def, k_def, adv_def));
            end
            if (got_sm !== exp_vec(m_sm, k_sm, adv_sm)) begin
                n_bad++;
                $display("FAIL stall_small k=%0d: got %h expected %h", k_sm, got_sm, exp_vec(m_sm, k_sm, adv_sm));
            end
            if (got_pol !== exp_vec(m_pol, k_pol, adv_pol)) begin
                n_bad++;
                $display("FAIL stall_pol k=%0d: got %h expected %h", k_pol, got_pol, exp_vec(m_pol, k_pol, adv_pol));
            end
        end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        repeat (300) step(1, 1, 1);
        n_cmp++;
        if (d_col !== 10'd300) begin
            n_bad++;
            $display("FAIL midframe_precondition: got col %0d expected 300", d_col);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp += 2;
        if (got_def !== exp_vec(m_def, 0, 0)) begin
            n_bad++;
            $display("FAIL midframe_reset_def: got %h expected %h", got_def, exp_vec(m_def, 0, 0));
        end
        if (got_sm !== exp_vec(m_sm, 0, 0)) begin
            n_bad++;
            $display("FAIL midframe_reset_small: got %h expected %h", got_sm, exp_vec(m_sm, 0, 0));
        end
        @(negedge clk);
        rst = 1'b0;
        k_def = 0; k_sm = 0; k_pol = 0;
        step(1, 1, 1);
        n_cmp++;
        if (got_def !== exp_vec(m_def, 1, 1) || d_col !== 10'd1) begin
            n_bad++;
            $display("FAIL midframe_restart: got %h expected %h", got_def, exp_vec(m_def, 1, 1));
        end
    endtask

    initial begin
        m_def = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0};
        m_sm  = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, 3};
        m_pol = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 0};
        test_reset();
        test_default_hsync();
        test_small_periods();
        test_delay_startup();
        test_enable_stall();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
